// File: rtl/demux_1x16_stream_pkg.sv
// rtl/demux_1x16_stream_pkg.sv - shared types and select-range helper for the stream demux
package demux_pkg;

   localparam int unsigned DEMUX_MAX_DEPTH = 16;

   typedef logic [15:0] drop_cnt_t;

   function automatic logic sel_in_range(input logic [31:0] sel, input int unsigned depth);
      return sel < depth;
   endfunction

endpackage

// File: rtl/demux_1x16_stream_if.sv
// rtl/demux_1x16_stream_if.sv - producer/consumer bundle for the stream demux
interface demux_1x16_stream_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int SEL_W = 4
);
   import demux_pkg::*;

   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH-1:0]       i;
   logic [SEL_W-1:0]       s;
   logic [DEPTH-1:0]       y_valid;
   logic [DEPTH-1:0]       y_ready;
   logic [DEPTH*WIDTH-1:0] y;
   logic                   sel_err;
   drop_cnt_t              drop_cnt;

   modport master (
      output in_valid, i, s, y_ready,
      input  in_ready, y_valid, y, sel_err, drop_cnt
   );

   modport slave (
      input  in_valid, i, s, y_ready,
      output in_ready, y_valid, y, sel_err, drop_cnt
   );

endinterface

// File: rtl/demux_1x16_stream_lane_reg.sv
// rtl/demux_1x16_stream_lane_reg.sv - one-entry lane holding register with load/drain
module demux_lane_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data_out
);
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;

   // A load wins over a drain so a same-cycle refill leaves no bubble.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = data_in;
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid    = valid_q;
   assign data_out = data_q;

endmodule

// File: rtl/demux_1x16_stream.sv
// rtl/demux_1x16_stream.sv - registered 1:DEPTH stream demux with out-of-range drop counting
module demux_1x16_stream
   import demux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int SEL_W = 4
) (
   input  logic clk,
   input  logic rst,
   demux_1x16_stream_if.slave bus
);
   logic [DEPTH-1:0]       sel_oh;
   logic [DEPTH-1:0]       lane_load;
   logic [DEPTH-1:0]       lane_valid;
   logic [DEPTH*WIDTH-1:0] lane_data;
   logic                   sel_ok;
   logic                   in_ready;
   logic                   accept;
   logic                   drop;
   logic                   sel_err_q, sel_err_d;
   drop_cnt_t              drop_cnt_q, drop_cnt_d;

   for (genvar k = 0; k < DEPTH; k++) begin : g_dec
      assign sel_oh[k] = (bus.s == SEL_W'(k));
   end

   // Out-of-range selects are always taken so the producer never blocks on a bad word.
   always_comb begin
      sel_ok   = sel_in_range(32'(bus.s), DEPTH);
      in_ready = 1'b0;
      if (!rst) begin
         in_ready = sel_ok ? |(sel_oh & (~lane_valid | bus.y_ready)) : 1'b1;
      end
      accept    = bus.in_valid && in_ready;
      drop      = accept && !sel_ok;
      lane_load = sel_oh & {DEPTH{accept}};
   end

   always_comb begin
      sel_err_d  = drop;
      drop_cnt_d = drop_cnt_q;
      if (drop && drop_cnt_q != 16'hFFFF) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_err_q  <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         sel_err_q  <= sel_err_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_lane
      demux_lane_reg #(.WIDTH(WIDTH)) u_lane (
         .clk      (clk),
         .rst      (rst),
         .load     (lane_load[k]),
         .data_in  (bus.i),
         .ready    (bus.y_ready[k]),
         .valid    (lane_valid[k]),
         .data_out (lane_data[k*WIDTH +: WIDTH])
      );
   end

   assign bus.in_ready = in_ready;
   assign bus.y_valid  = lane_valid;
   assign bus.y        = lane_data;
   assign bus.sel_err  = sel_err_q;
   assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux_1x16_stream.sv
// tb/tb_demux_1x16_stream.sv - directed self-checking bench for the stream demux
module tb_demux_1x16_stream;
   logic clk;
   logic rst_a;
   logic rst_b;
   int   checks;
   int   failures;

   demux_1x16_stream_if #(.WIDTH(32), .DEPTH(16), .SEL_W(4)) ifa ();
   demux_1x16_stream_if #(.WIDTH(32), .DEPTH(12), .SEL_W(4)) ifb ();

   demux_1x16_stream #(.WIDTH(32), .DEPTH(16), .SEL_W(4)) u_dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (ifa.slave)
   );

   demux_1x16_stream #(.WIDTH(32), .DEPTH(12), .SEL_W(4)) u_dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (ifb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] lane_a(input int k);
      return ifa.y[k*32 +: 32];
   endfunction

   function automatic logic [31:0] lane_b(input int k);
      return ifb.y[k*32 +: 32];
   endfunction

   initial begin
      int stalls;
      checks   = 0;
      failures = 0;
      rst_a = 1'b1;
      rst_b = 1'b1;
      ifa.in_valid = 1'b1;
      ifa.i        = 32'hDEAD_BEEF;
      ifa.s        = 4'd0;
      ifa.y_ready  = 16'hFFFF;
      ifb.in_valid = 1'b0;
      ifb.i        = '0;
      ifb.s        = '0;
      ifb.y_ready  = 12'hFFF;

      // reset state, input blocked during reset
      step();
      #1 check("rst_in_ready", 64'(ifa.in_ready), 64'd0);
      step();
      check("rst_y_valid", 64'(ifa.y_valid), 64'd0);
      check("rst_y_zero", 64'(ifa.y[63:0]), 64'd0);
      check("rst_drop", 64'(ifa.drop_cnt), 64'd0);
      check("rst_sel_err", 64'(ifa.sel_err), 64'd0);
      rst_a = 1'b0;
      ifa.in_valid = 1'b0;

      // 1: single word to lane 3
      ifa.in_valid = 1'b1;
      ifa.i        = 32'hA5A5_0001;
      ifa.s        = 4'd3;
      #1 check("t1_in_ready", 64'(ifa.in_ready), 64'd1);
      step();
      ifa.in_valid = 1'b0;
      check("t1_y_valid", 64'(ifa.y_valid), 64'h0008);
      check("t1_lane3", 64'(lane_a(3)), 64'hA5A5_0001);
      step();
      check("t1_drain", 64'(ifa.y_valid), 64'h0000);

      // 2/3: lane 5 stalls, other lanes keep flowing
      ifa.y_ready  = 16'hFFFF & ~16'h0020;
      ifa.in_valid = 1'b1;
      ifa.s        = 4'd5;
      ifa.i        = 32'h11;
      step();
      ifa.i = 32'h22;
      #1 check("t2_stall_ready", 64'(ifa.in_ready), 64'd0);
      step();
      check("t2_lane5_hold", 64'(lane_a(5)), 64'h11);
      check("t2_lane5_valid", 64'(ifa.y_valid[5]), 64'd1);
      ifa.s = 4'd9;
      ifa.i = 32'h33;
      #1 check("t3_other_ready", 64'(ifa.in_ready), 64'd1);
      step();
      check("t3_y_valid", 64'(ifa.y_valid), 64'h0220);
      check("t3_lane9", 64'(lane_a(9)), 64'h33);
      check("t3_lane5", 64'(lane_a(5)), 64'h11);
      ifa.s       = 4'd5;
      ifa.i       = 32'h22;
      ifa.y_ready = 16'hFFFF;
      #1 check("t2_refill_ready", 64'(ifa.in_ready), 64'd1);
      step();
      ifa.in_valid = 1'b0;
      check("t2_no_bubble", 64'(ifa.y_valid), 64'h0020);
      check("t2_lane5_new", 64'(lane_a(5)), 64'h22);
      step();
      check("t2_drain", 64'(ifa.y_valid), 64'h0000);

      // 5: back-to-back across all lanes
      stalls = 0;
      for (int k = 0; k < 16; k++) begin
         ifa.in_valid = 1'b1;
         ifa.s        = 4'(k);
         ifa.i        = 32'hB000_0000 + 32'(k);
         #1 if (!ifa.in_ready) stalls++;
         step();
         check($sformatf("t5_valid_%0d", k), 64'(ifa.y_valid), 64'(16'h1 << k));
         check($sformatf("t5_lane_%0d", k), 64'(lane_a(k)), 64'hB000_0000 + 64'(k));
      end
      ifa.in_valid = 1'b0;
      check("t5_stalls", 64'(stalls), 64'd0);
      step();

      // 6: reset with held words and pending input
      ifa.y_ready  = 16'hFFFF & ~16'h0084;
      ifa.in_valid = 1'b1;
      ifa.s        = 4'd2;
      ifa.i        = 32'h0202;
      step();
      ifa.s = 4'd7;
      ifa.i = 32'h0707;
      step();
      check("t6_full", 64'(ifa.y_valid), 64'h0084);
      ifa.s = 4'd4;
      ifa.i = 32'h0404;
      rst_a = 1'b1;
      #1 check("t6_rst_ready", 64'(ifa.in_ready), 64'd0);
      step();
      check("t6_y_valid", 64'(ifa.y_valid), 64'h0000);
      check("t6_lane2", 64'(lane_a(2)), 64'h0);
      check("t6_drop", 64'(ifa.drop_cnt), 64'd0);
      rst_a = 1'b0;
      ifa.in_valid = 1'b0;
      step();
      check("t6_not_taken", 64'(ifa.y_valid), 64'h0000);

      // 4: DEPTH=12, out-of-range selects
      step();
      rst_b = 1'b0;
      ifb.y_ready  = 12'hFFD;
      ifb.in_valid = 1'b1;
      ifb.s        = 4'd1;
      ifb.i        = 32'h0101;
      step();
      check("t4_lane1", 64'(lane_b(1)), 64'h0101);
      ifb.s = 4'd13;
      ifb.i = 32'hBAD0;
      #1 check("t4_oor_ready", 64'(ifb.in_ready), 64'd1);
      step();
      ifb.in_valid = 1'b0;
      check("t4_sel_err", 64'(ifb.sel_err), 64'd1);
      check("t4_drop1", 64'(ifb.drop_cnt), 64'd1);
      check("t4_y_valid", 64'(ifb.y_valid), 64'h002);
      step();
      check("t4_pulse_once", 64'(ifb.sel_err), 64'd0);
      check("t4_drop_hold", 64'(ifb.drop_cnt), 64'd1);
      ifb.in_valid = 1'b1;
      ifb.s        = 4'd12;
      step();
      ifb.in_valid = 1'b0;
      check("t4_s12_drop", 64'(ifb.drop_cnt), 64'd2);
      check("t4_s12_lanes", 64'(ifb.y_valid), 64'h002);
      ifb.in_valid = 1'b1;
      ifb.s        = 4'd15;
      for (int n = 0; n < 65533; n++) @(posedge clk);
      #1 check("t4_sat_reach", 64'(ifb.drop_cnt), 64'hFFFF);
      step();
      step();
      check("t4_sat_hold", 64'(ifb.drop_cnt), 64'hFFFF);
      check("t4_sat_err", 64'(ifb.sel_err), 64'd1);
      ifb.in_valid = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
